// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - byte-wide instruction fetch sequencer with valid/ready output
//
// Purpose:
//   Holds the PC, issues four byte reads per instruction, assembles them
//   big-endian (byte at PC lands in bits 31:24), presents the word to decode
//   with a valid/ready handshake, applies redirects, and traps illegal fetch
//   addresses in a sticky FAULT state.
//
// Ports:
//   clk             system clock, all state on posedge
//   rst             synchronous active-high reset
//   en              fetch enable (sampled in IDLE and on handshake in HOLD)
//   mem_rd          byte read strobe
//   mem_addr        byte address of current read
//   mem_rdata       read data, valid the cycle after mem_rd
//   redirect_valid  branch/jump taken
//   redirect_addr   new PC (byte address)
//   instr_valid     instr/instr_pc/pc_next valid
//   instr_ready     decode accepts instruction
//   instr           assembled instruction
//   instr_pc        zero-extended address of instr
//   pc_next         instr_pc + 4
//   fault           illegal fetch address, sticky until redirect or reset

module fetch_sequencer #(
   parameter int ADDR_W    = 8,
   parameter int MEM_BYTES = 150,
   parameter int RESET_PC  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_addr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr,
   output logic [31:0]       instr_pc,
   output logic [31:0]       pc_next,
   output logic              fault
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LAST,
      S_HOLD,
      S_FAULT
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [1:0]          byte_cnt_q, byte_cnt_d;
   logic [23:0]         shift_q, shift_d;
   logic [31:0]         instr_q, instr_d;

   logic [31:0]         pc_ext;
   logic [31:0]         pc_plus4;
   logic                redir_ok;
   logic                cur_ok;
   logic                next_ok;

   // Word-aligned, no bits above the PC width, and all four bytes inside memory.
   function automatic logic addr_ok(input logic [31:0] a);
      logic [32:0] last_byte;
      last_byte = {1'b0, a} + 33'd3;
      addr_ok   = (a[1:0] == 2'b00) &&
                  ((a >> ADDR_W) == 32'd0) &&
                  (last_byte <= 33'(MEM_BYTES - 1));
   endfunction

   assign pc_ext   = 32'(pc_q);
   assign pc_plus4 = pc_ext + 32'd4;
   assign redir_ok = addr_ok(redirect_addr);
   assign cur_ok   = addr_ok(pc_ext);
   assign next_ok  = addr_ok(pc_plus4);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= ADDR_W'(RESET_PC);
         byte_cnt_q <= 2'd0;
         shift_q    <= 24'd0;
         instr_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         instr_q    <= instr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      instr_d    = instr_q;

      case (state_q)
         S_IDLE: begin
            if (redirect_valid) begin
               if (redir_ok) begin
                  pc_d       = redirect_addr[ADDR_W-1:0];
                  byte_cnt_d = 2'd0;
                  state_d    = en ? S_FETCH : S_IDLE;
               end else begin
                  state_d = S_FAULT;
               end
            end else if (en) begin
               byte_cnt_d = 2'd0;
               state_d    = cur_ok ? S_FETCH : S_FAULT;
            end
         end

         S_FETCH: begin
            if (redirect_valid) begin
               // Abort: partial bytes are overwritten by the restarted fetch.
               byte_cnt_d = 2'd0;
               if (redir_ok) begin
                  pc_d    = redirect_addr[ADDR_W-1:0];
                  state_d = S_FETCH;
               end else begin
                  state_d = S_FAULT;
               end
            end else begin
               // Data for the byte issued last cycle is on mem_rdata now.
               if (byte_cnt_q != 2'd0) begin
                  shift_d = {shift_q[15:0], mem_rdata};
               end
               if (byte_cnt_q == 2'd3) begin
                  byte_cnt_d = 2'd0;
                  state_d    = S_LAST;
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end

         S_LAST: begin
            if (redirect_valid) begin
               byte_cnt_d = 2'd0;
               if (redir_ok) begin
                  pc_d    = redirect_addr[ADDR_W-1:0];
                  state_d = S_FETCH;
               end else begin
                  state_d = S_FAULT;
               end
            end else begin
               instr_d = {shift_q, mem_rdata};
               state_d = S_HOLD;
            end
         end

         S_HOLD: begin
            if (redirect_valid) begin
               // Redirect wins over pc+4 and over en, handshake or not.
               byte_cnt_d = 2'd0;
               if (redir_ok) begin
                  pc_d    = redirect_addr[ADDR_W-1:0];
                  state_d = S_FETCH;
               end else begin
                  state_d = S_FAULT;
               end
            end else if (instr_ready) begin
               pc_d       = pc_plus4[ADDR_W-1:0];
               byte_cnt_d = 2'd0;
               if (en) begin
                  state_d = next_ok ? S_FETCH : S_FAULT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_FAULT: begin
            if (redirect_valid && redir_ok) begin
               pc_d       = redirect_addr[ADDR_W-1:0];
               byte_cnt_d = 2'd0;
               state_d    = S_FETCH;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_rd      = (state_q == S_FETCH);
   assign mem_addr    = pc_q + ADDR_W'(byte_cnt_q);
   assign instr_valid = (state_q == S_HOLD);
   assign instr       = instr_q;
   assign instr_pc    = pc_ext;
   assign pc_next     = pc_plus4;
   assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

   logic        clk;
   logic        rst;
   logic        en;
   logic        mem_rd;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc_next;
   logic        fault;

   fetch_sequencer #(
      .ADDR_W(8),
      .MEM_BYTES(150),
      .RESET_PC(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .mem_rd(mem_rd),
      .mem_addr(mem_addr),
      .mem_rdata(mem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_addr(redirect_addr),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr(instr),
      .instr_pc(instr_pc),
      .pc_next(pc_next),
      .fault(fault)
   );

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  mem [0:255];
   int          cyc;
   int          n_cmp;
   int          n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      mem_rdata = 8'h00;
   end
   always @(posedge clk) cyc <= cyc + 1;

   // Byte memory with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted instruction is popped against the scoreboard.
   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_instr_pc", instr_pc, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_instr", instr, e.word);
            chk("sb_instr_pc", instr_pc, e.pc);
            chk("sb_pc_next", pc_next, e.pc + 32'd4);
            chk("sb_accept_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2, t3;
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      {mem[0], mem[1], mem[2], mem[3]}             = 32'h2008_0005;
      {mem[4], mem[5], mem[6], mem[7]}             = 32'h2409_0007;
      {mem[8], mem[9], mem[10], mem[11]}           = 32'h0109_5020;
      {mem[12], mem[13], mem[14], mem[15]}         = 32'hAABB_CCDD;
      {mem[16], mem[17], mem[18], mem[19]}         = 32'hDEAD_BEEF;
      {mem[144], mem[145], mem[146], mem[147]}     = 32'h1122_3344;

      rst = 1'b1; en = 1'b0; instr_ready = 1'b0;
      redirect_valid = 1'b0; redirect_addr = 32'd0;
      repeat (3) tick();
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_pc_next", pc_next, 32'd4);
      rst = 1'b0;
      tick();

      // First fetch: four byte reads, valid five cycles after entering FETCH.
      en = 1'b1;
      tick();
      t0 = cyc;
      for (int k = 0; k < 4; k++) begin
         chk("f0_mem_rd", 32'(mem_rd), 32'd1);
         chk("f0_mem_addr", 32'(mem_addr), 32'(k));
         tick();
      end
      chk("f0_last_mem_rd", 32'(mem_rd), 32'd0);
      chk("f0_last_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("f0_valid", 32'(instr_valid), 32'd1);
      sb.push_back('{32'h2008_0005, 32'd0, t0 + 15});

      // Decode stalls for 10 cycles: output stable, no reads.
      for (int i = 0; i < 10; i++) begin
         chk("hold_valid", 32'(instr_valid), 32'd1);
         chk("hold_instr", instr, 32'h2008_0005);
         chk("hold_instr_pc", instr_pc, 32'd0);
         chk("hold_mem_rd", 32'(mem_rd), 32'd0);
         tick();
      end

      // Streaming with ready high: one instruction every 6 cycles.
      sb.push_back('{32'h2409_0007, 32'd4, t0 + 21});
      sb.push_back('{32'h0109_5020, 32'd8, t0 + 27});
      instr_ready = 1'b1;
      tick();
      chk("resume_mem_rd", 32'(mem_rd), 32'd1);
      chk("resume_mem_addr", 32'(mem_addr), 32'd4);
      repeat (14) tick();

      // Redirect to 0x10 while fetching pc 12 at byte_cnt=2.
      chk("pre_redir_mem_addr", 32'(mem_addr), 32'd14);
      redirect_valid = 1'b1; redirect_addr = 32'h10; en = 1'b0;
      tick();
      redirect_valid = 1'b0;
      chk("redir_mem_rd", 32'(mem_rd), 32'd1);
      chk("redir_mem_addr", 32'(mem_addr), 32'h10);
      sb.push_back('{32'hDEAD_BEEF, 32'h10, t0 + 36});
      repeat (6) tick();
      chk("idle_mem_rd", 32'(mem_rd), 32'd0);
      chk("idle_valid", 32'(instr_valid), 32'd0);

      // Illegal redirects.
      redirect_valid = 1'b1; redirect_addr = 32'h0E;
      tick();
      chk("unaligned_fault", 32'(fault), 32'd1);
      chk("unaligned_mem_rd", 32'(mem_rd), 32'd0);
      chk("unaligned_valid", 32'(instr_valid), 32'd0);
      redirect_addr = 32'h94;
      tick();
      chk("oob_fault", 32'(fault), 32'd1);
      chk("oob_mem_rd", 32'(mem_rd), 32'd0);
      redirect_addr = 32'h100;
      tick();
      chk("highbit_fault", 32'(fault), 32'd1);
      redirect_addr = 32'h08;
      tick();
      redirect_valid = 1'b0;
      t1 = cyc;
      chk("recover_fault", 32'(fault), 32'd0);
      chk("recover_mem_rd", 32'(mem_rd), 32'd1);
      chk("recover_mem_addr", 32'(mem_addr), 32'h08);
      sb.push_back('{32'h0109_5020, 32'h08, t1 + 5});
      repeat (6) tick();

      // Highest legal word address: 0x90..0x93.
      redirect_valid = 1'b1; redirect_addr = 32'h90;
      tick();
      redirect_valid = 1'b0;
      chk("edge_idle_fault", 32'(fault), 32'd0);
      en = 1'b1;
      tick();
      t2 = cyc;
      en = 1'b0;
      chk("edge_mem_addr", 32'(mem_addr), 32'h90);
      sb.push_back('{32'h1122_3344, 32'h90, t2 + 5});
      repeat (6) tick();

      // pc is now 0x94, whose last byte is outside memory.
      en = 1'b1;
      tick();
      chk("seq_oob_fault", 32'(fault), 32'd1);
      chk("seq_oob_mem_rd", 32'(mem_rd), 32'd0);

      // Reset in the middle of a fetch.
      redirect_valid = 1'b1; redirect_addr = 32'h04;
      tick();
      redirect_valid = 1'b0;
      chk("mid_b0_addr", 32'(mem_addr), 32'h04);
      tick();
      chk("mid_b1_addr", 32'(mem_addr), 32'h05);
      rst = 1'b1;
      tick();
      chk("midrst_mem_rd", 32'(mem_rd), 32'd0);
      chk("midrst_valid", 32'(instr_valid), 32'd0);
      chk("midrst_fault", 32'(fault), 32'd0);
      chk("midrst_instr_pc", instr_pc, 32'd0);
      chk("midrst_instr", instr, 32'd0);
      rst = 1'b0;
      tick();
      t3 = cyc;
      en = 1'b0;
      chk("postrst_mem_addr", 32'(mem_addr), 32'd0);
      sb.push_back('{32'h2008_0005, 32'd0, t3 + 5});
      repeat (8) tick();

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that sequences the byte-wide instruction memory for the fetch stage of the MIPS 32-bit core.
- Holds the PC and issues four byte reads per instruction. Assembles them big-endian: byte at PC is bits 31:24.
- Presents the instruction to decode with a valid/ready handshake, applies branch/jump redirects, and flags illegal fetch addresses.

Parameters:
- ADDR_W, 8, width of PC and mem_addr.
- MEM_BYTES, 150, number of bytes in instruction memory; legal byte addresses are 0..MEM_BYTES-1.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- en  in  1  fetch enable; sampled in IDLE and on handshake in HOLD.
- mem_rd  out  1  byte read strobe.
- mem_addr  out  ADDR_W  byte address of current read.
- mem_rdata  in  8  read data, valid the cycle after mem_rd.
- redirect_valid  in  1  branch/jump taken.
- redirect_addr  in  32  new PC (byte address).
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts instruction.
- instr  out  32  assembled instruction.
- instr_pc  out  32  zero-extended address of instr.
- pc_next  out  32  instr_pc + 4, 32-bit add, no wrap.
- fault  out  1  illegal fetch address, sticky.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE, pc=RESET_PC, byte_cnt=0.
  - instr=0, instr_valid=0, mem_rd=0, fault=0.
  - Reset mid-fetch discards all partial bytes.
- States: IDLE, FETCH, LAST, HOLD, FAULT.
- Legality check (LC), applied to any address about to be loaded into the fetch path. An address is illegal if any of:
  - bits [1:0] != 0;
  - any bit above ADDR_W-1 is set;
  - addr+3 > MEM_BYTES-1.
- IDLE:
  - mem_rd=0.
  - redirect_valid loads pc with redirect_addr if LC passes; otherwise go to FAULT.
  - en=1 goes to FETCH if LC(pc) passes, else FAULT.
- FETCH, 4 cycles, byte_cnt 0..3:
  - mem_rd=1, mem_addr=pc+byte_cnt.
  - Byte k is captured at the edge ending the cycle after its issue.
  - After byte_cnt=3 go to LAST.
- LAST, 1 cycle:
  - mem_rd=0.
  - Capture byte 3 into instr[7:0], set instr_valid=1, go to HOLD.
- Latency: entering FETCH at cycle N gives instr_valid=1 from cycle N+5. Throughput is 1 instruction per 6 cycles with instr_ready held high.
- HOLD:
  - instr, instr_pc and pc_next are stable while instr_valid=1 and instr_ready=0. No memory reads.
  - instr_valid & instr_ready completes the handshake.
  - On handshake: pc+=4, then FETCH if en=1 (LC on the new pc, FAULT on fail), else IDLE. instr_valid drops next cycle.
- Redirect in FETCH/LAST:
  - Abort and discard captured bytes; instr_valid stays 0.
  - pc<=redirect_addr, byte_cnt<=0.
  - Next state is FETCH (LC pass) or FAULT.
- Redirect in HOLD:
  - A handshake in the same cycle still counts as consumed.
  - pc<=redirect_addr (not pc+4), instr_valid<=0.
  - Next state is FETCH/FAULT regardless of en.
- Redirect has priority over every sequential PC update.
- FAULT:
  - fault=1, mem_rd=0, instr_valid=0.
  - Exit only via rst, or via redirect_valid with an LC-passing address: clears fault and goes to FETCH.
- mem_rdata is ignored whenever the byte it belongs to was aborted.

Test Plan:
- Memory bytes 0..3 = 20,08,00,05; rst, then en=1 at cycle 0 -> mem_addr 0,1,2,3 in cycles 0-3; instr_valid=1 at cycle 5; instr=0x20080005, instr_pc=0, pc_next=4.
- instr_ready held 1, en=1 -> instr_pc sequence 0,4,8 with instr_valid pulses exactly 6 cycles apart.
- instr_ready=0 for 10 cycles after valid -> instr, instr_pc constant; mem_rd=0 throughout; on ready=1, next fetch starts at pc=4.
- redirect_valid with addr 0x10 during byte_cnt=2 -> no valid for old PC; mem_addr restarts at 0x10 next cycle; next instr_pc=0x10.
- Illegal addresses:
  - Redirect to 0x0E -> fault=1, mem_rd=0.
  - Redirect to 0x94 -> fault (0x97 > 149).
  - Then redirect to 0x08 -> fault=0, fetch resumes, instr_pc=0x08.
- rst asserted mid-FETCH at byte_cnt=1 -> next cycle state IDLE, pc=0, instr_valid=0, mem_rd=0, fault=0.
